// File: rtl/floating_div.sv
// Iterative IEEE-754 single-precision divider, one restoring quotient bit per cycle.
// Specials resolve on the accepting edge; finite operands take 26 cycles.
module floating_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] out,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DIV  = 2'd1;
    localparam logic [1:0] NORM = 2'd2;

    logic [1:0]        state;
    logic [4:0]        cnt;
    logic [24:0]       q;
    logic [24:0]       r;
    logic [23:0]       mb;
    logic signed [9:0] e;
    logic              s;

    logic              s_in;
    logic              zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
    logic              spec;
    logic [31:0]       spec_val;
    logic [9:0]        e_in;

    logic [24:0]       diff;
    logic              qbit;
    logic [24:0]       r_keep;

    logic signed [9:0] ef;
    logic [22:0]       frac;
    logic [31:0]       norm_val;

    always_comb begin
        s_in   = a[31] ^ b[31];
        zero_a = (a[30:23] == 8'h00);
        zero_b = (b[30:23] == 8'h00);
        inf_a  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        inf_b  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        nan_a  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        nan_b  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        e_in   = {2'b00, a[30:23]} - {2'b00, b[30:23]} + 10'd127;
        spec     = 1'b1;
        spec_val = {s_in, 31'd0};
        if (nan_a || nan_b || (inf_a && inf_b) || (zero_a && zero_b))
            spec_val = {s_in, 8'hFF, 23'd1};
        else if (inf_a || zero_b)
            spec_val = {s_in, 8'hFF, 23'd0};
        else if (zero_a || inf_b)
            spec_val = {s_in, 31'd0};
        else
            spec = 1'b0;
    end

    always_comb begin
        diff   = r - {1'b0, mb};
        qbit   = (r >= {1'b0, mb});
        r_keep = qbit ? diff : r;
    end

    // A quotient below 1.0 lands one bit lower and costs one exponent step.
    always_comb begin
        ef   = q[24] ? e : e - 10'sd1;
        frac = q[24] ? q[23:1] : q[22:0];
        if (ef >= 10'sd255)
            norm_val = {s, 8'hFF, 23'd0};
        else if (ef <= 10'sd0)
            norm_val = {s, 31'd0};
        else
            norm_val = {s, ef[7:0], frac};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 5'd0;
            q     <= 25'd0;
            r     <= 25'd0;
            mb    <= 24'd0;
            e     <= 10'sd0;
            s     <= 1'b0;
            out   <= 32'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        s <= s_in;
                        if (spec) begin
                            out  <= spec_val;
                            done <= 1'b1;
                        end else begin
                            r     <= {2'b01, a[22:0]};
                            mb    <= {1'b1, b[22:0]};
                            e     <= $signed(e_in);
                            q     <= 25'd0;
                            cnt   <= 5'd0;
                            busy  <= 1'b1;
                            state <= DIV;
                        end
                    end
                end
                DIV: begin
                    r   <= {r_keep[23:0], 1'b0};
                    q   <= {q[23:0], qbit};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd24)
                        state <= NORM;
                end
                NORM: begin
                    out   <= norm_val;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/floating_div.md
# floating_div

Iterative IEEE-754 single-precision divider that computes `a / b` for the same operand format the multiplier datapath uses. It is the inverse-operation companion to the combinational multiplier. It uses a start/busy/done handshake and a one-quotient-bit-per-cycle restoring mantissa divider, so it trades latency for area. Special operands resolve in one cycle. Finite operands take a fixed 26 cycles.

## Interface
- No parameters; width fixed at 32 (1 sign, 8 exponent, 23 fraction).
- Clocking (already decided): one clock; reset is synchronous and active-high.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  32  dividend; captured on the accepting edge.
- `b`  in  32  divisor; captured on the accepting edge.
- `out`  out  32  registered quotient; holds until the next result.
- `busy`  out  1  high while a division is in progress.
- `done`  out  1  one-cycle pulse; `out` is valid when high.

## Operation
- States: IDLE, DIV, NORM.
- IDLE + `start`:
  - Captures `a`, `b`.
  - Sign `s = a[31]^b[31]` always, including for special results.
- Operand classification:
  - Exponent 0: zero (flush-to-zero, fraction ignored).
  - Exponent 0xFF with fraction 0: inf.
  - Exponent 0xFF with fraction ≠ 0: NaN.
- Special cases are resolved on the accepting edge, in priority order; the FSM stays IDLE:
  - Either operand NaN, inf/inf, or 0/0: `{s,8'hFF,23'd1}`.
  - inf/finite, or nonzero finite/0: `{s,8'hFF,23'd0}`.
  - 0/finite-nonzero, or finite/inf: `{s,31'd0}`.
- Normal path:
  - `ma={1,a[22:0]}`, `mb={1,b[22:0]}` (24 bits).
  - Remainder `r` (25 bits) starts at `ma`.
  - Exponent `e` is a signed 10-bit value, `a[30:23]-b[30:23]+127`.
  - Counter starts at 0; FSM goes to DIV.
- DIV, one step per cycle, 25 cycles:
  - `qbit = (r >= mb)`.
  - If `qbit` is set, `r = r - mb`.
  - Then `r = r << 1`, and `q = {q[23:0], qbit}` (25-bit `q`).
  - Moves to NORM after the 25th step.
- NORM:
  - If `q[24]`: fraction `q[23:1]`, exponent `e`.
  - Else: fraction `q[22:0]`, exponent `e-1`.
  - Rounding is truncation only.
- Exponent saturation, applied after the adjustment:
  - Exponent ≥ 255: `{s,8'hFF,23'd0}`.
  - Exponent ≤ 0: `{s,31'd0}`.
- NORM writes `out`, pulses `done`, and returns to IDLE.
- `start` while busy is ignored.
- Inputs `a` and `b` may change freely after the accepting edge.

## Timing
- Reset:
  - `out=0`, `busy=0`, `done=0`, state IDLE.
  - Counter, `q`, `r`, `e` are cleared.
  - Reset mid-division aborts it with no `done`; `out` returns to 0.
  - `rst` has priority over `start` in the same cycle.
- Edge 0 is the edge where `start` is sampled high in IDLE.
- Special operands:
  - `out` updates at edge 0.
  - `done` is high for the cycle after edge 0.
  - `busy` stays 0.
- Normal operands:
  - `busy=1` after edges 0..25.
  - Quotient steps occur at edges 1..25.
  - Edge 26 writes `out`, sets `done=1`, and sets `busy=0`.
  - `done` drops at edge 27 unless a new special-case result is produced.
- Back-to-back operation:
  - `start` is accepted in the same cycle that `done` is high (FSM is IDLE).
  - A new special case then pulses `done` again in the next cycle.
  - Throughput is one finite division per 27 cycles.
- `done` is never high for two cycles from the same request.

## Test plan
- 6.0/2.0, `0x40C00000`/`0x40000000` → `out=0x40400000`; `done` in the cycle after edge 26 only; `busy` high for exactly 26 cycles.
- 1.0/3.0, `0x3F800000`/`0x40400000` → `0x3EAAAAAA` (truncated).
- -6.0/2.0, `0xC0C00000`/`0x40000000` → `0xC0400000`.
- Special cases, each with `done` the cycle after edge 0 and `busy=0`:
  - 1.0/0.0 → `0x7F800000`.
  - 0/0 → `0x7F800001`.
  - `0x7FC00000`/1.0 → `0x7F800001`.
  - 0x80000000/2.0 → `0x80000000`.
- Saturation:
  - `0x7F000000`/`0x00800000` → `0x7F800000`.
  - `0x00800000`/`0x7F000000` → `0x00000000`.
- Control:
  - Assert `rst` at cycle 10 of a 6.0/2.0 division → no `done`; `out=0`, `busy=0`.
  - `start` held high throughout 6.0/2.0 → the second request is accepted only on the `done` cycle.
  - Random `a`/`b` toggling during DIV does not change the result.
